noc_send_port_arbiter: RTL and testbench

Shares one network send port among NUM_REQ local requesters with packet-atomic round-robin arbitration and per-VC credit flow control. Sits between the user-side flit sources of one router endpoint and the Network's `send_ports_N_putFlit` / `send_ports_N_getCredits` methods. It guarantees that flits of different packets are never interleaved on a VC and that a flit is never injected without a downstream buffer credit.

---
 rtl/noc_send_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_noc_send_port_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_send_port_arbiter.sv
// noc_send_port_arbiter: shares one network send port among NUM_REQ
// requesters, packet-atomic round-robin, per-VC credit flow control.
module noc_send_port_arbiter #(
  parameter  int NUM_REQ         = 4,
  parameter  int FLIT_DATA_WIDTH = 32,
  parameter  int DEST_BITS       = 2,
  parameter  int NUM_VCS         = 2,
  parameter  int VC_BITS         = 1,
  parameter  int BUF_DEPTH       = 8,
  localparam int FLIT_W = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH,
  localparam int CR_W   = 1 + VC_BITS,
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1)
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*FLIT_W-1:0]   req_flit,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [FLIT_W-1:0]           send_putFlit_flit_in,
  output logic                        EN_send_putFlit,
  input  logic [CR_W-1:0]             send_getCredits,
  output logic                        EN_send_getCredits,
  output logic [NUM_VCS*CNT_W-1:0]    credits_avail,
  output logic                        err_credit_overflow
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int VC_LO = FLIT_DATA_WIDTH;

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [VC_BITS-1:0] r_vc;
  logic [CNT_W-1:0]   r_cnt [NUM_VCS];
  logic               r_err;
  logic               r_en_cr;
  logic               r_out_en;
  logic [FLIT_W-1:0]  r_out_flit;

  logic [NUM_VCS-1:0] w_vc_ok;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_win_nx;
  logic               w_acc;
  logic [FLIT_W-1:0]  w_sel_flit;
  logic               w_tail;
  logic [VC_BITS-1:0] w_acc_vc;
  logic [FLIT_W-1:0]  w_out;
  logic               w_cr_v;
  logic [VC_BITS-1:0] w_cr_vc;
  logic [NUM_VCS-1:0] w_dec;
  logic [NUM_VCS-1:0] w_inc;
  logic               w_unused_bits;

  // Which VCs currently have at least one downstream credit
  always_comb begin
    w_vc_ok = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      w_vc_ok[v] = (r_cnt[v] != '0);
    end
  end

  // Eligibility: valid and a credit on the VC the flit will use
  always_comb begin
    logic [VC_BITS-1:0] ev;
    ev     = '0;
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ev = (r_state == S_LOCKED) ? r_vc
         : req_flit[i*FLIT_W + VC_LO +: VC_BITS];
      w_elig[i] = req_valid[i]
               && (int'(ev) < NUM_VCS)
               && w_vc_ok[ev];
    end
  end

  // Grant: owner only when locked, else round-robin from r_rr_ptr
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    w_win = '0;
    w_gnt = '0;
    if (RST_N) begin
      if (r_state == S_LOCKED) begin
        w_win = r_owner;
        w_gnt[r_owner] = w_elig[r_owner];
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
          if (!found && w_elig[idx]) begin
            found = 1'b1;
            w_win = idx;
          end
        end
        if (found) w_gnt[w_win] = 1'b1;
      end
    end
  end

  assign req_ready  = w_gnt;
  assign w_acc      = |w_gnt;
  assign w_sel_flit = req_flit[w_win*FLIT_W +: FLIT_W];
  assign w_tail     = w_sel_flit[FLIT_W-2];
  assign w_acc_vc   = (r_state == S_LOCKED) ? r_vc
                    : w_sel_flit[VC_LO +: VC_BITS];
  assign w_win_nx   = (int'(w_win) == NUM_REQ - 1) ? '0
                    : w_win + PTR_W'(1);
  assign w_out      = {1'b1,
                       w_sel_flit[FLIT_W-2 -: 1+DEST_BITS],
                       w_acc_vc,
                       w_sel_flit[FLIT_DATA_WIDTH-1:0]};
  assign w_unused_bits = w_sel_flit[FLIT_W-1];

  assign w_cr_v  = r_en_cr && send_getCredits[CR_W-1];
  assign w_cr_vc = send_getCredits[VC_BITS-1:0];

  // Per-VC consume/return strobes for this cycle
  always_comb begin
    w_dec = '0;
    w_inc = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      w_dec[v] = w_acc && (w_acc_vc == VC_BITS'(v));
      w_inc[v] = w_cr_v && (w_cr_vc == VC_BITS'(v));
    end
  end

  // Packet-lock FSM and round-robin pointer
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_vc     <= '0;
    end else if (w_acc) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_tail) begin
            r_rr_ptr <= w_win_nx;
          end else begin
            r_state <= S_LOCKED;
            r_owner <= w_win;
            r_vc    <= w_acc_vc;
          end
        end
        S_LOCKED: begin
          if (w_tail) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= w_win_nx;
          end
        end
      endcase
    end
  end

  // Credit counters; a return into a full counter is a protocol error
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        r_cnt[v] <= CNT_W'(BUF_DEPTH);
      end
      r_err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (w_dec[v] && !w_inc[v]) begin
          r_cnt[v] <= r_cnt[v] - CNT_W'(1);
        end else if (w_inc[v] && !w_dec[v]) begin
          if (r_cnt[v] == CNT_W'(BUF_DEPTH)) begin
            r_err <= 1'b1;
          end else begin
            r_cnt[v] <= r_cnt[v] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Registered send port and credit-drain enable
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_out_en   <= 1'b0;
      r_out_flit <= '0;
      r_en_cr    <= 1'b0;
    end else begin
      r_out_en   <= w_acc;
      r_out_flit <= w_acc ? w_out : '0;
      r_en_cr    <= 1'b1;
    end
  end

  // Flatten counters onto the status bus
  always_comb begin
    credits_avail = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      credits_avail[v*CNT_W +: CNT_W] = r_cnt[v];
    end
  end

  assign send_putFlit_flit_in = r_out_flit;
  assign EN_send_putFlit      = r_out_en;
  assign EN_send_getCredits   = r_en_cr;
  assign err_credit_overflow  = r_err;

endmodule

// File: tb/tb_noc_send_port_arbiter.sv
// tb_noc_send_port_arbiter: directed stimulus with a flit scoreboard
// and a decoupled output monitor.
module tb_noc_send_port_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int DB  = 2;
  localparam int NV  = 2;
  localparam int VB  = 1;
  localparam int BD  = 8;
  localparam int FW  = 2 + DB + VB + DW;
  localparam int CRW = 1 + VB;
  localparam int CW  = 4;

  logic               CLK = 1'b0;
  logic               RST_N;
  logic [NR-1:0]      req_valid;
  logic [NR*FW-1:0]   req_flit;
  logic [NR-1:0]      req_ready;
  logic [FW-1:0]      send_putFlit_flit_in;
  logic               EN_send_putFlit;
  logic [CRW-1:0]     send_getCredits;
  logic               EN_send_getCredits;
  logic [NV*CW-1:0]   credits_avail;
  logic               err_credit_overflow;

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] mon_e;

  always #5 CLK = ~CLK;

  noc_send_port_arbiter #(
    .NUM_REQ(NR), .FLIT_DATA_WIDTH(DW), .DEST_BITS(DB),
    .NUM_VCS(NV), .VC_BITS(VB), .BUF_DEPTH(BD)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .req_valid(req_valid),
    .req_flit(req_flit),
    .req_ready(req_ready),
    .send_putFlit_flit_in(send_putFlit_flit_in),
    .EN_send_putFlit(EN_send_putFlit),
    .send_getCredits(send_getCredits),
    .EN_send_getCredits(EN_send_getCredits),
    .credits_avail(credits_avail),
    .err_credit_overflow(err_credit_overflow)
  );

  function automatic logic [FW-1:0] mk(
    input logic v, input logic t, input logic [1:0] d,
    input logic vc, input logic [31:0] data);
    return {v, t, d, vc, data};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic setf(input int i, input logic [FW-1:0] f);
    req_flit[i*FW +: FW] = f;
  endtask

  task automatic cyc(input logic [NR-1:0] rdy, input string nm);
    @(negedge CLK);
    chk(nm, req_ready, rdy);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  // Monitor: every injected flit must match the head of the scoreboard
  always @(negedge CLK) begin
    if (EN_send_putFlit) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL flit_unexpected got %0h want none",
                 send_putFlit_flit_in);
      end else begin
        mon_e = exp_q.pop_front();
        chk("flit", send_putFlit_flit_in, mon_e);
      end
    end else if (send_putFlit_flit_in !== '0) begin
      chk("flit_idle_zero", send_putFlit_flit_in, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0;
    req_valid = '0;
    req_flit = '0;
    send_getCredits = '0;
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("rst_ready", req_ready, 0);
    chk("rst_en", EN_send_putFlit, 0);
    chk("rst_flit", send_putFlit_flit_in, 0);
    chk("rst_en_cr", EN_send_getCredits, 0);
    chk("rst_credits", credits_avail, 8'h88);
    chk("rst_err", err_credit_overflow, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("en_cr_after_rst", EN_send_getCredits, 1);
    @(posedge CLK); #1;

    // single flit from req 1
    setf(1, mk(0, 1, 2, 0, 32'h10));
    req_valid = 4'b0010;
    exp_q.push_back(mk(1, 1, 2, 0, 32'h10));
    cyc(4'b0010, "t1_rdy");
    req_valid = '0;
    @(negedge CLK);
    chk("t1_credits", credits_avail, 8'h87);
    @(posedge CLK); #1;

    // round robin over 0,1,3 on VC1, two rounds
    do_reset();
    setf(0, mk(0, 1, 1, 1, 32'h20));
    setf(1, mk(0, 1, 0, 1, 32'h21));
    setf(3, mk(0, 1, 3, 1, 32'h23));
    req_valid = 4'b1011;
    exp_q.push_back(mk(1, 1, 1, 1, 32'h20));
    cyc(4'b0001, "t2_g0");
    exp_q.push_back(mk(1, 1, 0, 1, 32'h21));
    cyc(4'b0010, "t2_g1");
    exp_q.push_back(mk(1, 1, 3, 1, 32'h23));
    cyc(4'b1000, "t2_g3");
    exp_q.push_back(mk(1, 1, 1, 1, 32'h20));
    cyc(4'b0001, "t2_g0_again");
    req_valid = '0;
    @(negedge CLK);
    chk("t2_credits", credits_avail, 8'h48);
    @(posedge CLK); #1;

    // packet atomicity; tail vc field is overridden by the head's vc
    do_reset();
    setf(0, mk(0, 0, 1, 0, 32'h11));
    req_valid = 4'b0001;
    exp_q.push_back(mk(1, 0, 1, 0, 32'h11));
    cyc(4'b0001, "t3_head");
    setf(0, mk(0, 1, 1, 1, 32'h12));
    setf(3, mk(0, 1, 3, 0, 32'h33));
    req_valid = 4'b1001;
    exp_q.push_back(mk(1, 1, 1, 0, 32'h12));
    cyc(4'b0001, "t3_tail_r3_blocked");
    req_valid = 4'b1000;
    exp_q.push_back(mk(1, 1, 3, 0, 32'h33));
    cyc(4'b1000, "t3_r3");
    req_valid = '0;
    @(negedge CLK);
    chk("t3_credits", credits_avail, 8'h85);
    @(posedge CLK); #1;

    // credit exhaustion on VC0 and recovery by one returned credit
    do_reset();
    setf(2, mk(0, 1, 0, 0, 32'h44));
    req_valid = 4'b0100;
    for (int k = 0; k < BD; k++) begin
      exp_q.push_back(mk(1, 1, 0, 0, 32'h44));
      cyc(4'b0100, "t4_acc");
    end
    @(negedge CLK);
    chk("t4_zero_credits", credits_avail, 8'h80);
    @(posedge CLK); #1;
    send_getCredits = 2'b10;
    cyc(4'b0000, "t4_stall");
    send_getCredits = '0;
    exp_q.push_back(mk(1, 1, 0, 0, 32'h44));
    cyc(4'b0100, "t4_ninth");
    cyc(4'b0000, "t4_stall_again");
    req_valid = '0;
    @(negedge CLK);
    chk("t4_credits_end", credits_avail, 8'h80);
    @(posedge CLK); #1;

    // overflow on full counter; simultaneous consume and return
    do_reset();
    send_getCredits = 2'b11;
    cyc(4'b0000, "t5_ovf_rdy");
    send_getCredits = '0;
    @(negedge CLK);
    chk("t5_ovf_cnt", credits_avail, 8'h88);
    chk("t5_ovf_err", err_credit_overflow, 1);
    @(posedge CLK); #1;
    setf(0, mk(0, 1, 0, 0, 32'h50));
    req_valid = 4'b0001;
    exp_q.push_back(mk(1, 1, 0, 0, 32'h50));
    cyc(4'b0001, "t5_acc");
    send_getCredits = 2'b10;
    exp_q.push_back(mk(1, 1, 0, 0, 32'h50));
    cyc(4'b0001, "t5_acc_ret");
    req_valid = '0;
    send_getCredits = '0;
    @(negedge CLK);
    chk("t5_sim_cnt", credits_avail, 8'h87);
    chk("t5_err_sticky", err_credit_overflow, 1);
    @(posedge CLK); #1;
    do_reset();
    @(negedge CLK);
    chk("t5_err_cleared", err_credit_overflow, 0);
    @(posedge CLK); #1;

    // reset while locked mid-packet
    setf(1, mk(0, 0, 2, 1, 32'h60));
    req_valid = 4'b0010;
    exp_q.push_back(mk(1, 0, 2, 1, 32'h60));
    cyc(4'b0010, "t6_head");
    setf(0, mk(0, 1, 0, 0, 32'h61));
    setf(2, mk(0, 1, 1, 0, 32'h62));
    req_valid = 4'b0101;
    cyc(4'b0000, "t6_locked_block");
    RST_N = 1'b0;
    cyc(4'b0000, "t6_rst_rdy");
    RST_N = 1'b1;
    @(negedge CLK);
    chk("t6_credits", credits_avail, 8'h88);
    chk("t6_en", EN_send_putFlit, 0);
    chk("t6_rdy", req_ready, 4'b0001);
    exp_q.push_back(mk(1, 1, 0, 0, 32'h61));
    @(posedge CLK); #1;
    req_valid = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
